fetch_pc_reg: RTL and testbench

//  Sequential front end of the SEQ core; consumer of the next-PC value.
//  - Holds the architectural PC and fetches from a combinational instruction-memory read port.
//  - Splits the instruction into icode/ifun/rA/rB/valC and computes valP.
//  - Tracks processor status with an AOK/HLT/ADR/INS FSM.
//  - Loads new_pc on each clock edge while status is AOK.

---
 rtl/fetch_pc_reg_if.sv | 36 +++
 rtl/fetch_pc_reg.sv | 115 +++++++++++
 tb/tb_fetch_pc_reg.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_pc_reg_if.sv
// Fetch-stage bus: next-PC / stall / imem read port in, PC + decoded fields out.
// With INSTR_COUNT_EN defined the bus also carries the retired-instruction count.
interface fetch_pc_reg_if;
  logic [63:0] new_pc;
  logic        stall;
  logic [79:0] imem_data;
  logic [63:0] imem_addr;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [1:0]  stat;
  logic        instr_valid;
`ifdef INSTR_COUNT_EN
  logic [63:0] instr_count;
`endif

  modport master (
`ifdef INSTR_COUNT_EN
    input  instr_count,
`endif
    output new_pc, stall, imem_data,
    input  imem_addr, pc, icode, ifun, rA, rB, valC, valP, stat, instr_valid
  );

  modport slave (
`ifdef INSTR_COUNT_EN
    output instr_count,
`endif
    input  new_pc, stall, imem_data,
    output imem_addr, pc, icode, ifun, rA, rB, valC, valP, stat, instr_valid
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// SEQ fetch front end: PC register, Y86 instruction split/length/legality, AOK/HLT/ADR/INS status.
// Optional INSTR_COUNT_EN adds a 64-bit retired-instruction counter on the bus.
module fetch_pc_reg #(
  parameter logic [63:0] RESET_PC   = 64'd0,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_reg_if.slave  bus
);
  typedef enum logic [1:0] {S_AOK = 2'd0, S_HLT = 2'd1, S_ADR = 2'd2, S_INS = 2'd3} stat_e;

  localparam logic [64:0] W_LIM = 65'(IMEM_BYTES);

  stat_e       r_stat, w_stat_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic [7:0]  w_b0, w_b1;
  logic [3:0]  w_icode, w_ifun, w_len, w_flen;
  logic        w_need_regs, w_has_valc, w_legal, w_addr_err;
  logic [64:0] w_end;
  logic [63:0] w_valc, w_valp;
  logic        w_instr_valid;

  assign w_b0    = bus.imem_data[7:0];
  assign w_b1    = bus.imem_data[15:8];
  assign w_icode = w_b0[7:4];
  assign w_ifun  = w_b0[3:0];

  always_comb begin
    w_need_regs = 1'b0;
    w_has_valc  = 1'b0;
    w_len       = 4'd1;
    w_legal     = 1'b0;
    case (w_icode)
      4'h0, 4'h1, 4'h9: w_legal = (w_ifun == 4'd0);
      4'h2: begin w_need_regs = 1'b1; w_len = 4'd2; w_legal = (w_ifun <= 4'd6); end
      4'h6: begin w_need_regs = 1'b1; w_len = 4'd2; w_legal = (w_ifun <= 4'd3); end
      4'hA, 4'hB: begin w_need_regs = 1'b1; w_len = 4'd2; w_legal = (w_ifun == 4'd0); end
      4'h7: begin w_has_valc = 1'b1; w_len = 4'd9; w_legal = (w_ifun <= 4'd6); end
      4'h8: begin w_has_valc = 1'b1; w_len = 4'd9; w_legal = (w_ifun == 4'd0); end
      4'h3, 4'h4, 4'h5: begin
        w_need_regs = 1'b1; w_has_valc = 1'b1; w_len = 4'd10; w_legal = (w_ifun == 4'd0);
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Register-byte instructions carry valC one byte later than jXX/call.
  always_comb begin
    w_valc = 64'd0;
    if (w_has_valc) w_valc = w_need_regs ? bus.imem_data[79:16] : bus.imem_data[71:8];
  end

  // An illegal opcode is treated as one byte long for both valP and the range check.
  assign w_flen     = w_legal ? w_len : 4'd1;
  assign w_valp     = r_pc + 64'(w_flen);
  assign w_end      = {1'b0, r_pc} + 65'(w_flen);
  assign w_addr_err = (w_end > W_LIM);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= S_AOK;
      r_pc   <= RESET_PC;
    end else begin
      r_stat <= w_stat_nxt;
      r_pc   <= w_pc_nxt;
    end
  end

  // Next state: only AOK moves; the fault states are absorbing until reset.
  always_comb begin
    w_stat_nxt = r_stat;
    w_pc_nxt   = r_pc;
    if (r_stat == S_AOK && !bus.stall) begin
      if (w_addr_err)          w_stat_nxt = S_ADR;
      else if (!w_legal)       w_stat_nxt = S_INS;
      else if (w_icode == 4'h0) begin
        w_stat_nxt = S_HLT;
        w_pc_nxt   = w_valp;
      end else                 w_pc_nxt   = bus.new_pc;
    end
  end

  // Outputs
  always_comb begin
    w_instr_valid = (r_stat == S_AOK) && w_legal;
  end

  assign bus.imem_addr   = r_pc;
  assign bus.pc          = r_pc;
  assign bus.icode       = w_icode;
  assign bus.ifun        = w_ifun;
  assign bus.rA          = w_need_regs ? w_b1[7:4] : 4'hF;
  assign bus.rB          = w_need_regs ? w_b1[3:0] : 4'hF;
  assign bus.valC        = w_valc;
  assign bus.valP        = w_valp;
  assign bus.stat        = r_stat;
  assign bus.instr_valid = w_instr_valid;

`ifdef INSTR_COUNT_EN
  logic [63:0] r_icnt;
  logic        w_retire;

  // Halt retires too; the count wraps naturally at 2^64.
  assign w_retire = (r_stat == S_AOK) && !bus.stall && w_legal && !w_addr_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_icnt <= 64'd0;
    else if (w_retire) r_icnt <= r_icnt + 64'd1;
  end

  assign bus.instr_count = r_icnt;
`endif
endmodule

// File: tb/tb_fetch_pc_reg.sv
// Directed bench for fetch_pc_reg: byte-array imem model, hand-computed expectations.
module tb_fetch_pc_reg;
  localparam int MEM_N = 1040;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  mem [0:MEM_N-1];
  logic [79:0] d;
  logic [63:0] a;
  int          checks = 0;
  int          errors = 0;

  fetch_pc_reg_if bus();

  fetch_pc_reg #(.RESET_PC(64'd0), .IMEM_BYTES(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; reads past the array return 0.
  always_comb begin
    d = '0;
    a = '0;
    for (int i = 0; i < 10; i++) begin
      a = bus.imem_addr + 64'(i);
      if (a < 64'(MEM_N)) d[8*i +: 8] = mem[a[10:0]];
    end
    bus.imem_data = d;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mem();
    for (int i = 0; i < MEM_N; i++) mem[i] = 8'h00;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  logic [7:0]  tb_b0   [8] = '{8'h26, 8'h27, 8'h63, 8'hC0, 8'h90, 8'h91, 8'h80, 8'hB0};
  logic        tb_vld  [8] = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1};
  logic [63:0] tb_valp [8] = '{64'd2, 64'd1, 64'd2, 64'd1, 64'd1, 64'd1, 64'd9, 64'd2};

  initial begin
    rst_n = 1'b0;
    bus.new_pc = 64'd0;
    bus.stall  = 1'b0;
    clr_mem();
    #3;
    chk("rst_pc",   bus.pc,   64'd0);
    chk("rst_stat", 64'(bus.stat), 64'd0);
    #9 rst_n = 1'b1;

    // irmovq $10,%rbx
    clr_mem();
    mem[0] = 8'h30; mem[1] = 8'hF3; mem[2] = 8'h0A;
    do_reset();
    chk("t1_icode", 64'(bus.icode), 64'h3);
    chk("t1_rA",    64'(bus.rA),    64'hF);
    chk("t1_rB",    64'(bus.rB),    64'h3);
    chk("t1_valC",  bus.valC,       64'd10);
    chk("t1_valP",  bus.valP,       64'd10);
    chk("t1_valid", 64'(bus.instr_valid), 64'd1);
    chk("t1_addr",  bus.imem_addr,  64'd0);
    bus.new_pc = 64'd10;
    tick();
    chk("t1_pc",    bus.pc,         64'd10);

    // Legality / length table at pc=0, stalled so pc never moves
    clr_mem();
    do_reset();
    bus.stall = 1'b1;
    for (int k = 0; k < 8; k++) begin
      mem[0] = tb_b0[k];
      #1;
      chk($sformatf("tbl_valid_%0h", tb_b0[k]), 64'(bus.instr_valid), 64'(tb_vld[k]));
      chk($sformatf("tbl_valP_%0h",  tb_b0[k]), bus.valP, tb_valp[k]);
    end
    bus.stall = 1'b0;

    // jmp 0x20 with a two-cycle stall
    clr_mem();
    mem[0] = 8'h70; mem[1] = 8'h20;
    do_reset();
    chk("t2_valC", bus.valC, 64'h20);
    chk("t2_valP", bus.valP, 64'd9);
    chk("t2_rA",   64'(bus.rA), 64'hF);
    bus.new_pc = 64'h20;
    bus.stall  = 1'b1;
    tick();
    chk("t2_stall1", bus.pc, 64'd0);
    tick();
    chk("t2_stall2", bus.pc, 64'd0);
    bus.stall = 1'b0;
    tick();
    chk("t2_pc", bus.pc, 64'h20);

    // nop at 0x20 -> 0x40, halt at 0x40
    mem[8'h20] = 8'h10;
    bus.new_pc = 64'h40;
    tick();
    chk("t3_pc40", bus.pc, 64'h40);
    chk("t3_valP", bus.valP, 64'h41);
    bus.new_pc = 64'd0;
    tick();
    chk("t3_hlt",  64'(bus.stat), 64'd1);
    chk("t3_pc41", bus.pc, 64'h41);
    tick();
    tick();
    chk("t3_frz_pc",   bus.pc, 64'h41);
    chk("t3_frz_stat", 64'(bus.stat), 64'd1);

    // irmovq at 1020 runs past 1024 -> ADR
    clr_mem();
    mem[0] = 8'h10;
    do_reset();
    bus.new_pc = 64'd1020;
    tick();
    chk("t4_pc", bus.pc, 64'd1020);
    mem[1020] = 8'h30; mem[1021] = 8'hF0;
    #1;
    chk("t4_pre_aok", 64'(bus.stat), 64'd0);
    tick();
    chk("t4_adr",  64'(bus.stat), 64'd2);
    chk("t4_hold", bus.pc, 64'd1020);
    // nop in the last byte stays in range
    clr_mem();
    mem[0] = 8'h10; mem[1023] = 8'h10;
    do_reset();
    bus.new_pc = 64'd1023;
    tick();
    chk("t4_pc1023", bus.pc, 64'd1023);
    chk("t4_valP",   bus.valP, 64'd1024);
    tick();
    chk("t4_aok", 64'(bus.stat), 64'd0);

    // OPq ifun 4 at 0x80 -> INS, then async reset mid-cycle
    clr_mem();
    mem[0] = 8'h10; mem[8'h80] = 8'h64;
    do_reset();
    bus.new_pc = 64'h80;
    tick();
    chk("t5_valid", 64'(bus.instr_valid), 64'd0);
    chk("t5_valP",  bus.valP, 64'h81);
    bus.new_pc = 64'h100;
    tick();
    chk("t5_ins", 64'(bus.stat), 64'd3);
    chk("t5_pc",  bus.pc, 64'h80);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_arst_stat", 64'(bus.stat), 64'd0);
    chk("t5_arst_pc",   bus.pc, 64'd0);
    rst_n = 1'b1;

`ifdef INSTR_COUNT_EN
    // 5 nops, 1 stall cycle, halt -> 6 retired
    clr_mem();
    for (int i = 0; i < 5; i++) mem[i] = 8'h10;
    do_reset();
    chk("t6_cnt0", bus.instr_count, 64'd0);
    for (int i = 0; i < 5; i++) begin
      bus.new_pc = 64'(i + 1);
      tick();
    end
    chk("t6_cnt5", bus.instr_count, 64'd5);
    bus.stall = 1'b1;
    tick();
    chk("t6_stall", bus.instr_count, 64'd5);
    bus.stall = 1'b0;
    tick();
    tick();
    chk("t6_cnt6", bus.instr_count, 64'd6);
    chk("t6_hlt",  64'(bus.stat), 64'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
